datapath_ctrl: RTL and testbench

- Moore/Mealy control FSM for the 8-bit general datapath (PC, IR, A register, 32x8 RAM, add/sub).
- Consumes the datapath status outputs IR[2:0] (opcode = IR[7:5]), Aeq0 and Apos.
- Produces every datapath control strobe: PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub, Asel, plus the datapath's synchronous clear.
- Sequencing: fetch, decode, then one execute state per opcode.

---
 rtl/datapath_ctrl.sv | 146 ++++++++++++++
 tb/tb_datapath_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: control FSM for the 8-bit general datapath
// (PC, IR, A register, 32x8 RAM, add/sub unit).
// Sequence per instruction: FETCH, DECODE, then one execute state per opcode.
//
// Ports:
//   Clock    in   system clock, rising edge
//   Reset    in   asynchronous active-low reset, forces START
//   IR[2:0]  in   opcode from datapath IR[7:5]
//   Aeq0     in   A == 0 flag
//   Apos     in   A >= 0 flag
//   Enter    in   operator strobe (pre-synchronised, level-sensitive)
//   DpReset  out  synchronous clear to the datapath
//   PCload   out  load PC
//   JMPmux   out  1: PC <= IR[4:0], 0: PC <= PC+1
//   IRload   out  load IR from RAM
//   Meminst  out  1: RAM address from PC, 0: from IR[4:0]
//   MemWr    out  RAM write enable
//   Aload    out  load A
//   Sub      out  1: subtract, 0: add
//   Asel     out  A source: 00 ALU, 01 data_in, 10 RAM
//   Halt     out  processor halted
//   State    out  current state register, for debug
//
// Parameter HALT_LOCK: 1 = HALT left only by Reset; 0 = Enter in HALT
// returns to FETCH without reloading PC.
module datapath_ctrl #(
  parameter bit HALT_LOCK = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] IR,
  input  logic       Aeq0,
  input  logic       Apos,
  input  logic       Enter,
  output logic       DpReset,
  output logic       PCload,
  output logic       JMPmux,
  output logic       IRload,
  output logic       Meminst,
  output logic       MemWr,
  output logic       Aload,
  output logic       Sub,
  output logic [1:0] Asel,
  output logic       Halt,
  output logic [3:0] State
);

  localparam logic [3:0] S_START  = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_INREL  = 4'd3;
  localparam logic [3:0] S_LOAD   = 4'd8;
  localparam logic [3:0] S_STORE  = 4'd9;
  localparam logic [3:0] S_ADD    = 4'd10;
  localparam logic [3:0] S_SUB    = 4'd11;
  localparam logic [3:0] S_INPUT  = 4'd12;
  localparam logic [3:0] S_JZ     = 4'd13;
  localparam logic [3:0] S_JPOS   = 4'd14;
  localparam logic [3:0] S_HALT   = 4'd15;

  logic [3:0] state_q;
  logic [3:0] state_d;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_START;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_START:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      // Execute states occupy 8..15, so the opcode maps directly.
      S_DECODE: state_d = {1'b1, IR};
      S_LOAD,
      S_STORE,
      S_ADD,
      S_SUB,
      S_JZ,
      S_JPOS:   state_d = S_FETCH;
      S_INPUT:  state_d = Enter ? S_INREL : S_INPUT;
      // Waiting for Enter release gives exactly one load per press.
      S_INREL:  state_d = Enter ? S_INREL : S_FETCH;
      S_HALT: begin
        if (!HALT_LOCK && Enter) begin
          state_d = S_FETCH;
        end
      end
      default:  state_d = S_START;
    endcase
  end

  // Outputs decode from the state register, so an asynchronous reset
  // drops any write or load strobe immediately.
  always_comb begin
    DpReset = 1'b0;
    PCload  = 1'b0;
    JMPmux  = 1'b0;
    IRload  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Asel    = 2'b00;
    Halt    = 1'b0;
    unique case (state_q)
      S_START: DpReset = 1'b1;
      S_FETCH: begin
        Meminst = 1'b1;
        IRload  = 1'b1;
        PCload  = 1'b1;
      end
      S_LOAD: begin
        Asel  = 2'b10;
        Aload = 1'b1;
      end
      S_STORE: MemWr = 1'b1;
      S_ADD:   Aload = 1'b1;
      S_SUB: begin
        Sub   = 1'b1;
        Aload = 1'b1;
      end
      S_INPUT: begin
        Asel  = 2'b01;
        Aload = Enter;
      end
      S_JZ: begin
        JMPmux = 1'b1;
        PCload = Aeq0;
      end
      S_JPOS: begin
        JMPmux = 1'b1;
        PCload = Apos;
      end
      S_HALT:  Halt = 1'b1;
      default: ;
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Self-checking bench for datapath_ctrl. Expected per-cycle outputs are
// generated instruction by instruction from the opcode behaviour table.
module tb_datapath_ctrl;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [2:0] IR = '0;
  logic       Aeq0 = 1'b0, Apos = 1'b0, Enter = 1'b0;

  logic       DpReset, PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub, Halt;
  logic [1:0] Asel;
  logic [3:0] State;
  logic       DpReset2, PCload2, JMPmux2, IRload2, Meminst2, MemWr2, Aload2, Sub2, Halt2;
  logic [1:0] Asel2;
  logic [3:0] State2;

  int checks = 0;
  int failures = 0;
  bit chk2 = 1'b1;

  always #5 Clock = ~Clock;

  datapath_ctrl #(.HALT_LOCK(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
    .DpReset(DpReset), .PCload(PCload), .JMPmux(JMPmux), .IRload(IRload),
    .Meminst(Meminst), .MemWr(MemWr), .Aload(Aload), .Sub(Sub), .Asel(Asel),
    .Halt(Halt), .State(State)
  );

  datapath_ctrl #(.HALT_LOCK(1'b0)) dut_nolock (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
    .DpReset(DpReset2), .PCload(PCload2), .JMPmux(JMPmux2), .IRload(IRload2),
    .Meminst(Meminst2), .MemWr(MemWr2), .Aload(Aload2), .Sub(Sub2), .Asel(Asel2),
    .Halt(Halt2), .State(State2)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       dpr, pcl, jmp, irl, mi, mw, al, sub;
    logic [1:0] asel;
    logic       halt;
  } exp_t;

  function automatic exp_t blank(input int st);
    exp_t e;
    e    = '0;
    e.st = 4'(st);
    return e;
  endfunction

  wire [14:0] obs1 = {State, DpReset, PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub, Asel, Halt};
  wire [14:0] obs2 = {State2, DpReset2, PCload2, JMPmux2, IRload2, Meminst2, MemWr2, Aload2, Sub2, Asel2, Halt2};

  task automatic check(input string tag, input exp_t e);
    checks++;
    assert (obs1 === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs1, 15'(e));
    end
    if (chk2) begin
      checks++;
      assert (obs2 === e) else begin
        failures++;
        $error("FAIL %s_nolock observed=%h expected=%h", tag, obs2, 15'(e));
      end
    end
  endtask

  // Called at posedge+1: drive inputs, check settled outputs, advance a cycle.
  task automatic cyc(input logic [2:0] ir, input logic aeq, input logic apos,
                     input logic ent, input string tag, input exp_t e);
    IR = ir; Aeq0 = aeq; Apos = apos; Enter = ent;
    #2;
    check(tag, e);
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    exp_t e;
    e = blank(0);
    e.dpr = 1'b1;
    Reset = 1'b0;
    chk2 = 1'b1;
    cyc(3'($urandom), 1'b0, 1'b0, 1'b0, "reset_hold0", e);
    cyc(3'($urandom), 1'b0, 1'b0, 1'b1, "reset_hold1", e);
    Reset = 1'b1;
    cyc(3'($urandom), 1'b0, 1'b0, 1'b0, "start", e);
  endtask

  // One complete instruction: fetch, decode, execute (k Enter-low INPUT
  // cycles, m extra Enter-high INREL cycles).
  task automatic run_instr(input int op, input logic aeq, input logic apos,
                           input int k, input int m);
    exp_t e;
    e = blank(1); e.mi = 1'b1; e.irl = 1'b1; e.pcl = 1'b1;
    cyc(3'($urandom), 1'($urandom), 1'($urandom), 1'b0, "fetch", e);
    e = blank(2);
    cyc(3'(op), 1'($urandom), 1'($urandom), 1'b0, "decode", e);
    e = blank(8 + op);
    case (op)
      0: begin e.asel = 2'b10; e.al = 1'b1; cyc(3'($urandom), aeq, apos, 1'b0, "exec_load", e); end
      1: begin e.mw = 1'b1; cyc(3'($urandom), aeq, apos, 1'b0, "exec_store", e); end
      2: begin e.al = 1'b1; cyc(3'($urandom), aeq, apos, 1'b0, "exec_add", e); end
      3: begin e.al = 1'b1; e.sub = 1'b1; cyc(3'($urandom), aeq, apos, 1'b0, "exec_sub", e); end
      4: begin
        e.asel = 2'b01;
        for (int i = 0; i < k; i++) cyc(3'($urandom), aeq, apos, 1'b0, "input_wait", e);
        e.al = 1'b1;
        cyc(3'($urandom), aeq, apos, 1'b1, "input_load", e);
        e = blank(3);
        for (int i = 0; i < m; i++) cyc(3'($urandom), aeq, apos, 1'b1, "inrel_hold", e);
        cyc(3'($urandom), aeq, apos, 1'b0, "inrel_release", e);
      end
      5: begin e.jmp = 1'b1; e.pcl = aeq; cyc(3'($urandom), aeq, apos, 1'b0, "exec_jz", e); end
      6: begin e.jmp = 1'b1; e.pcl = apos; cyc(3'($urandom), aeq, apos, 1'b0, "exec_jpos", e); end
      default: ;
    endcase
  endtask

  initial begin
    exp_t e;
    @(posedge Clock);
    #1;

    // Reset and the ALU / store / branch / input directed cases.
    do_reset();
    run_instr(0, 1'b0, 1'b0, 0, 0);
    run_instr(2, 1'b0, 1'b0, 0, 0);
    run_instr(3, 1'b0, 1'b0, 0, 0);
    run_instr(1, 1'b0, 1'b0, 0, 0);
    run_instr(5, 1'b1, 1'b0, 0, 0);
    run_instr(5, 1'b0, 1'b1, 0, 0);
    run_instr(6, 1'b1, 1'b0, 0, 0);
    run_instr(6, 1'b0, 1'b1, 0, 0);
    run_instr(4, 1'b0, 1'b0, 5, 2);
    run_instr(4, 1'b0, 1'b0, 0, 0);

    // Randomized instruction stream (opcodes 0..6).
    for (int n = 0; n < 200; n++) begin
      run_instr(int'($urandom_range(0, 6)), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    end

    // HALT: the locked instance holds; the unlocked one leaves on Enter.
    e = blank(1); e.mi = 1'b1; e.irl = 1'b1; e.pcl = 1'b1;
    cyc(3'($urandom), 1'b0, 1'b0, 1'b0, "halt_fetch", e);
    cyc(3'd7, 1'b0, 1'b0, 1'b0, "halt_decode", blank(2));
    e = blank(15); e.halt = 1'b1;
    cyc(3'($urandom), 1'b0, 1'b0, 1'b1, "halt_enter", e);
    chk2 = 1'b0;
    checks++;
    assert ({State2, Halt2, IRload2, PCload2} === {4'd1, 1'b0, 1'b1, 1'b1}) else begin
      failures++;
      $error("FAIL nolock_exit observed=%h expected=%h", {State2, Halt2, IRload2, PCload2}, 7'h0B);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(3'($urandom), 1'($urandom), 1'($urandom), 1'(i), "halt_hold", e);
    end
    do_reset();
    run_instr(0, 1'b0, 1'b0, 0, 0);

    // Asynchronous reset in the middle of STORE kills MemWr at once.
    e = blank(1); e.mi = 1'b1; e.irl = 1'b1; e.pcl = 1'b1;
    cyc(3'($urandom), 1'b0, 1'b0, 1'b0, "mid_fetch", e);
    cyc(3'd1, 1'b0, 1'b0, 1'b0, "mid_decode", blank(2));
    e = blank(9); e.mw = 1'b1;
    #2;
    check("mid_store", e);
    Reset = 1'b0;
    #1;
    e = blank(0); e.dpr = 1'b1;
    check("mid_store_abort", e);
    @(posedge Clock);
    #1;
    do_reset();
    run_instr(3, 1'b0, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
